// File: rtl/pxl_pack.sv
// pxl_pack -- RGB888 to RGB565 packer feeding the DRAM write FIFO.
//
// Converts each decoded 24-bit pixel to RGB565 and packs 8 pixels per
// 128-bit word (pixel 0 in [15:0]). Words are written to the write FIFO as
// {seg_start, data}. Every SEG_WORDS words form one line segment, which is
// one DRAM burst. Each completed segment publishes a {line, segment} tag in
// a small queue for the DRAM write engine.
//
// Ports:
//   clk, rst_n     pixel clock, synchronous active-low reset
//   vsync, de      frame sync and data enable from the decoder
//   pixel          {R,G,B} 8 bits each, valid while de=1
//   fifo_full      write FIFO full
//   fifo_wr_en     FIFO write strobe (never asserted while fifo_full=1)
//   fifo_din       [128]=first word of segment, [127:0]=8 RGB565 pixels
//   seg_ack        write engine consumed the head segment (1-cycle pulse)
//   wr_probe       tag queue non-empty
//   cline, cpxl    line index / segment index of the head tag
//   ovf            sticky overflow / protocol error flag
module pxl_pack #(
   parameter int SEG_WORDS = 64,
   parameter int TAG_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vsync,
   input  logic         de,
   input  logic [23:0]  pixel,
   input  logic         fifo_full,
   output logic         fifo_wr_en,
   output logic [128:0] fifo_din,
   input  logic         seg_ack,
   output logic         wr_probe,
   output logic [11:0]  cline,
   output logic [1:0]   cpxl,
   output logic         ovf
);

   localparam int WC_W = $clog2(SEG_WORDS);
   localparam int TP_W = $clog2(TAG_DEPTH);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(SEG_WORDS - 1);

   typedef enum logic [1:0] {IDLE, ACT, PAD, SKIP} state_t;

   state_t          state, state_nx;
   logic            de_d, vs_d;
   logic [2:0]      lane;
   logic [127:0]    pbuf;
   logic [WC_W-1:0] word_cnt;
   logic [1:0]      seg_idx;
   logic [11:0]     line_cnt;

   // The word packed on one edge is written (or dropped) in the next cycle;
   // these hold its tag bookkeeping until then.
   logic            wr_pend;
   logic            pend_last;
   logic [13:0]     pend_tag;

   logic [13:0]     q_mem [TAG_DEPTH];
   logic [TP_W-1:0] q_head, q_tail;
   logic [TP_W:0]   q_cnt;

   logic vs_rise, de_fall, drop, wr_ok, push, pop, q_full, accept, tag_lost;
   logic clr_seg, take_px, pack_fill, pack_pad, err_pad, seg_clr, pack;
   logic [127:0] pack_data;
   logic [11:0]  pack_line;

   // Only the top bits of each colour survive the conversion.
   logic unused_px;
   assign unused_px = ^{pixel[18:16], pixel[9:8], pixel[2:0]};

   function automatic logic [15:0] to_rgb565(input logic [4:0] r,
                                             input logic [5:0] g,
                                             input logic [4:0] b);
      return {r, g, b};
   endfunction

   assign vs_rise    = vsync & ~vs_d;
   assign de_fall    = de_d & ~de;
   assign drop       = wr_pend & fifo_full;
   assign wr_ok      = wr_pend & ~fifo_full;
   assign fifo_wr_en = wr_ok;
   assign push       = wr_ok & pend_last;

   assign pop      = seg_ack & (q_cnt != '0);
   assign q_full   = (q_cnt == (TP_W+1)'(TAG_DEPTH));
   // A simultaneous pop frees the slot, so a push into a full queue is
   // still accepted in that cycle.
   assign accept   = push & (~q_full | pop);
   assign tag_lost = push & ~accept;

   assign wr_probe = (q_cnt != '0);
   assign cline    = wr_probe ? q_mem[q_head][13:2] : 12'd0;
   assign cpxl     = wr_probe ? q_mem[q_head][1:0]  : 2'd0;

   always_comb begin
      state_nx  = state;
      clr_seg   = 1'b0;
      take_px   = 1'b0;
      pack_fill = 1'b0;
      pack_pad  = 1'b0;
      err_pad   = 1'b0;
      seg_clr   = 1'b0;
      if (vs_rise) begin
         state_nx = ACT;
         clr_seg  = 1'b1;
      end else if (drop) begin
         // A drop coinciding with the end of the line needs no SKIP phase.
         state_nx = de_fall ? ACT : SKIP;
         clr_seg  = 1'b1;
      end else begin
         case (state)
            IDLE: ;
            ACT: begin
               if (de_fall) begin
                  if (lane == 3'd0 && word_cnt == '0) begin
                     seg_clr = 1'b1;
                  end else begin
                     pack_fill = (lane != 3'd0);
                     state_nx  = PAD;
                  end
               end else if (de) begin
                  take_px = 1'b1;
               end
            end
            PAD: begin
               if (de) begin
                  err_pad  = 1'b1;
                  state_nx = SKIP;
                  clr_seg  = 1'b1;
               end else if (word_cnt == '0) begin
                  seg_clr  = 1'b1;
                  state_nx = ACT;
               end else begin
                  pack_pad = 1'b1;
               end
            end
            SKIP: begin
               if (de_fall) begin
                  clr_seg  = 1'b1;
                  state_nx = ACT;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      pack      = pack_fill | pack_pad | (take_px & (lane == 3'd7));
      pack_data = pbuf;
      if (pack_pad)
         pack_data = '0;
      else if (take_px)
         pack_data = {to_rgb565(pixel[23:19], pixel[15:10], pixel[7:3]), pbuf[111:0]};
      // PAD runs after the de falling edge has already advanced line_cnt.
      pack_line = pack_pad ? (line_cnt - 12'd1) : line_cnt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         de_d      <= 1'b0;
         vs_d      <= 1'b0;
         lane      <= '0;
         pbuf      <= '0;
         word_cnt  <= '0;
         seg_idx   <= '0;
         line_cnt  <= '0;
         wr_pend   <= 1'b0;
         pend_last <= 1'b0;
         pend_tag  <= '0;
         fifo_din  <= '0;
         ovf       <= 1'b0;
      end else begin
         state   <= state_nx;
         de_d    <= de;
         vs_d    <= vsync;
         wr_pend <= pack;

         if (vs_rise)
            line_cnt <= '0;
         else if (de_fall)
            line_cnt <= line_cnt + 12'd1;

         if (pack) begin
            fifo_din  <= {(word_cnt == '0), pack_data};
            pend_last <= (word_cnt == WC_LAST);
            pend_tag  <= {pack_line, seg_idx};
         end

         if (clr_seg) begin
            word_cnt <= '0;
            seg_idx  <= '0;
            lane     <= '0;
            pbuf     <= '0;
         end else if (pack) begin
            word_cnt <= word_cnt + WC_W'(1);
            if (word_cnt == WC_LAST)
               seg_idx <= seg_idx + 2'd1;
            lane <= '0;
            pbuf <= '0;
         end else if (take_px) begin
            pbuf[{lane, 4'b0000} +: 16] <= to_rgb565(pixel[23:19], pixel[15:10], pixel[7:3]);
            lane <= lane + 3'd1;
         end else if (seg_clr) begin
            seg_idx <= '0;
         end

         if (drop | err_pad | tag_lost)
            ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_head <= '0;
         q_tail <= '0;
         q_cnt  <= '0;
      end else begin
         if (accept)
            q_tail <= q_tail + TP_W'(1);
         if (pop)
            q_head <= q_head + TP_W'(1);
         if (accept && !pop)
            q_cnt <= q_cnt + (TP_W+1)'(1);
         else if (pop && !accept)
            q_cnt <= q_cnt - (TP_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         q_mem[q_tail] <= pend_tag;
   end

endmodule
